// File: rtl/fetch_stage.sv
// Instruction fetch + IF/ID register: one outstanding imem request, PC+4 sequencing, redirect/stall handling.
// Latency: request accepted at edge N, response no earlier than cycle N+1, IF/ID loads on the response edge (min 2 cycles/instr).
// Backpressure: req_valid holds a stable address until ready; stall parks a returning word in a one-entry skid buffer.
//
// Ports:
//   clk, rst_n                      clock (rising edge), asynchronous active-low reset
//   stall                           hold IF/ID and PC
//   redirect_valid, redirect_pc     control-flow change; kills IF/ID, overrides stall
//   imem_req_valid/addr/ready       fetch request handshake (word-aligned address)
//   imem_resp_valid/data            fetch response, one per accepted request
//   if_id_valid, instr_out          IF/ID instruction to decode (NOP_INSTR when empty)
//   if_id_pc, if_id_pc_plus4        PC of instr_out and its sequential successor
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        if_id_valid,
    output logic [31:0] instr_out,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc_plus4
);

    localparam logic [1:0] S_REQ  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    logic [1:0]  r_state;
    logic        r_run;        // low during reset and for the first edge after it, gating req_valid
    logic [31:0] r_pc;
    logic [31:0] r_req_pc;     // PC of the request currently in flight / buffered
    logic        r_stale;      // in-flight response belongs to a redirected-away path
    logic        r_skid_vld;
    logic [31:0] r_skid_dat;
    logic        r_if_id_valid;
    logic [31:0] r_instr;
    logic [31:0] r_if_id_pc;
    logic [31:0] r_if_id_pc4;

    logic        w_accept;
    logic        w_resp;
    logic        w_load_resp;
    logic        w_load_skid;
    logic [31:0] w_load_dat;
    logic [31:0] w_req_pc4;
    logic [31:0] w_redir_pc;

    assign imem_req_valid = r_run && (r_state == S_REQ);
    assign imem_req_addr  = r_pc;

    assign w_accept    = imem_req_valid && imem_req_ready;
    assign w_resp      = (r_state == S_WAIT) && imem_resp_valid;
    assign w_load_resp = w_resp && !r_stale && !stall;
    assign w_load_skid = (r_state == S_HOLD) && r_skid_vld && !stall;
    assign w_load_dat  = w_load_skid ? r_skid_dat : imem_resp_data;
    assign w_req_pc4   = r_req_pc + 32'd4;
    assign w_redir_pc  = {redirect_pc[31:2], 2'b00};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_REQ;
            r_run         <= 1'b0;
            r_pc          <= RESET_PC;
            r_req_pc      <= RESET_PC;
            r_stale       <= 1'b0;
            r_skid_vld    <= 1'b0;
            r_skid_dat    <= NOP_INSTR;
            r_if_id_valid <= 1'b0;
            r_instr       <= NOP_INSTR;
            r_if_id_pc    <= 32'd0;
            r_if_id_pc4   <= 32'd4;
        end else begin
            r_run <= 1'b1;
            if (redirect_valid) begin
                // Kill IF/ID and restart at the target, even under stall.
                r_if_id_valid <= 1'b0;
                r_instr       <= NOP_INSTR;
                r_pc          <= w_redir_pc;
                r_skid_vld    <= 1'b0;
                case (r_state)
                    S_REQ: begin
                        if (w_accept) begin
                            // Request left this edge for the old path: drop its response.
                            r_stale <= 1'b1;
                            r_state <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (imem_resp_valid) begin
                            // Response consumed (and discarded) right now; nothing left in flight.
                            r_stale <= 1'b0;
                            r_state <= S_REQ;
                        end else begin
                            r_stale <= 1'b1;
                        end
                    end
                    default: r_state <= S_REQ;
                endcase
            end else begin
                case (r_state)
                    S_REQ: begin
                        if (w_accept) begin
                            r_req_pc <= r_pc;
                            r_state  <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (imem_resp_valid) begin
                            if (r_stale) begin
                                // r_pc already holds the redirect target.
                                r_stale <= 1'b0;
                                r_state <= S_REQ;
                            end else if (stall) begin
                                r_skid_vld <= 1'b1;
                                r_skid_dat <= imem_resp_data;
                                r_state    <= S_HOLD;
                            end else begin
                                r_pc    <= w_req_pc4;
                                r_state <= S_REQ;
                            end
                        end
                    end
                    default: begin
                        if (!stall) begin
                            r_skid_vld <= 1'b0;
                            r_pc       <= w_req_pc4;
                            r_state    <= S_REQ;
                        end
                    end
                endcase

                if (!stall) begin
                    if (w_load_resp || w_load_skid) begin
                        r_if_id_valid <= 1'b1;
                        r_instr       <= w_load_dat;
                        r_if_id_pc    <= r_req_pc;
                        r_if_id_pc4   <= w_req_pc4;
                    end else begin
                        // Bubble: PC fields keep their last value, only the instruction is killed.
                        r_if_id_valid <= 1'b0;
                        r_instr       <= NOP_INSTR;
                    end
                end
            end
        end
    end

    assign if_id_valid    = r_if_id_valid;
    assign instr_out      = r_instr;
    assign if_id_pc       = r_if_id_pc;
    assign if_id_pc_plus4 = r_if_id_pc4;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: sequencing, handshake hold, stall skid, redirect, reset, PC wrap.
// Inputs driven on the falling edge, outputs sampled on the falling edge.
// A 1-cycle memory model answers accepted requests unless the sequence takes over the response pins.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        if_id_valid;
    logic [31:0] instr_out, if_id_pc, if_id_pc_plus4;

    // Second instance for the PC wrap case, driven by hand.
    logic        w_req_valid, w_ready, w_resp_valid;
    logic [31:0] w_req_addr, w_resp_data;
    logic        w_if_valid;
    logic [31:0] w_instr, w_if_pc, w_if_pc4;

    int n_chk = 0;
    int n_bad = 0;

    logic        mem_auto;
    logic        pend;
    logic [31:0] pend_addr;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .if_id_valid(if_id_valid), .instr_out(instr_out),
        .if_id_pc(if_id_pc), .if_id_pc_plus4(if_id_pc_plus4)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk(clk), .rst_n(rst_n), .stall(1'b0),
        .redirect_valid(1'b0), .redirect_pc(32'd0),
        .imem_req_valid(w_req_valid), .imem_req_addr(w_req_addr),
        .imem_req_ready(w_ready),
        .imem_resp_valid(w_resp_valid), .imem_resp_data(w_resp_data),
        .if_id_valid(w_if_valid), .instr_out(w_instr),
        .if_id_pc(w_if_pc), .if_id_pc_plus4(w_if_pc4)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h00: mem_word = 32'h0050_0093;
            32'h04: mem_word = 32'h00A0_0113;
            32'h08: mem_word = 32'h4020_8233;
            32'h0C: mem_word = 32'h0020_81B3;
            32'h40: mem_word = 32'h0010_0293;
            32'h80: mem_word = 32'hFE00_0EE3;
            default: mem_word = {a[15:0], 16'h0013};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance until IF/ID shows a live instruction, bounded.
    task automatic wait_vld(input string tag, input int bound);
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (if_id_valid) break;
        end
        chk(tag, 32'(if_id_valid), 32'd1);
    endtask

    // Memory: a request accepted at edge N is answered during cycle N+1.
    initial begin
        pend = 1'b0;
        pend_addr = 32'd0;
        forever begin
            @(negedge clk);
            #1;
            if (mem_auto) begin
                if (pend) begin
                    imem_resp_valid = 1'b1;
                    imem_resp_data  = mem_word(pend_addr);
                    pend = 1'b0;
                end else begin
                    imem_resp_valid = 1'b0;
                end
                if (imem_req_valid && imem_req_ready) begin
                    pend = 1'b1;
                    pend_addr = imem_req_addr;
                end
            end else begin
                pend = 1'b0;
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'd0;
        imem_req_ready = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data = 32'd0;
        mem_auto = 1'b1;
        w_ready = 1'b0;
        w_resp_valid = 1'b0;
        w_resp_data = 32'd0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_req_vld", 32'(imem_req_valid), 32'd0);
        chk("rst_if_vld", 32'(if_id_valid), 32'd0);
        chk("rst_instr", instr_out, NOP);
        chk("rst_pc", if_id_pc, 32'd0);
        chk("rst_pc4", if_id_pc_plus4, 32'd4);

        // Sequential fetch, one instruction every second cycle
        rst_n = 1'b1;
        imem_req_ready = 1'b1;
        wait_vld("seq0_vld", 10);
        chk("seq0_pc", if_id_pc, 32'h0);
        chk("seq0_instr", instr_out, 32'h0050_0093);
        chk("seq0_next_addr", imem_req_addr, 32'h4);
        @(negedge clk);
        chk("seq_bubble_vld", 32'(if_id_valid), 32'd0);
        chk("seq_bubble_instr", instr_out, NOP);
        @(negedge clk);
        chk("seq4_vld", 32'(if_id_valid), 32'd1);
        chk("seq4_pc", if_id_pc, 32'h4);
        chk("seq4_pc4", if_id_pc_plus4, 32'h8);
        chk("seq4_instr", instr_out, 32'h00A0_0113);

        // ready low for 3 cycles at pc 8: request held stable
        imem_req_ready = 1'b0;
        chk("hold_vld0", 32'(imem_req_valid), 32'd1);
        chk("hold_addr0", imem_req_addr, 32'h8);
        for (int i = 1; i < 3; i++) begin
            @(negedge clk);
            chk("hold_vld", 32'(imem_req_valid), 32'd1);
            chk("hold_addr", imem_req_addr, 32'h8);
        end
        imem_req_ready = 1'b1;
        @(negedge clk);
        chk("hold_accepted", 32'(imem_req_valid), 32'd0);
        wait_vld("pc8_vld", 6);
        chk("pc8_pc", if_id_pc, 32'h8);
        chk("pc8_instr", instr_out, 32'h4020_8233);

        // Stall while the 0xC response returns
        stall = 1'b1;
        repeat (2) @(negedge clk);
        chk("stall_hold_pc", if_id_pc, 32'h8);
        chk("stall_hold_instr", instr_out, 32'h4020_8233);
        chk("stall_hold_vld", 32'(if_id_valid), 32'd1);
        chk("stall_no_req", 32'(imem_req_valid), 32'd0);
        @(negedge clk);
        chk("stall_hold2_instr", instr_out, 32'h4020_8233);
        chk("stall_no_req2", 32'(imem_req_valid), 32'd0);
        stall = 1'b0;
        @(negedge clk);
        chk("unstall_vld", 32'(if_id_valid), 32'd1);
        chk("unstall_instr", instr_out, 32'h0020_81B3);
        chk("unstall_pc", if_id_pc, 32'hC);
        chk("unstall_next_vld", 32'(imem_req_valid), 32'd1);
        chk("unstall_next_addr", imem_req_addr, 32'h10);

        // Redirect while waiting for pc 0x10; the late response must be dropped
        mem_auto = 1'b0;
        @(negedge clk);
        chk("redir_waiting", 32'(imem_req_valid), 32'd0);
        redirect_valid = 1'b1;
        redirect_pc = 32'h43;
        @(negedge clk);
        redirect_valid = 1'b0;
        chk("redir_kill_vld", 32'(if_id_valid), 32'd0);
        chk("redir_kill_instr", instr_out, NOP);
        chk("redir_still_wait", 32'(imem_req_valid), 32'd0);
        imem_resp_valid = 1'b1;
        imem_resp_data = 32'hDEAD_0010;
        @(negedge clk);
        imem_resp_valid = 1'b0;
        mem_auto = 1'b1;
        chk("stale_dropped_vld", 32'(if_id_valid), 32'd0);
        chk("stale_dropped_instr", instr_out, NOP);
        chk("redir_req_vld", 32'(imem_req_valid), 32'd1);
        chk("redir_req_addr", imem_req_addr, 32'h40);
        wait_vld("pc40_vld", 6);
        chk("pc40_pc", if_id_pc, 32'h40);
        chk("pc40_instr", instr_out, 32'h0010_0293);

        // Redirect and stall together, coinciding with a live response
        @(negedge clk);
        stall = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h80;
        @(negedge clk);
        chk("rs_kill_vld", 32'(if_id_valid), 32'd0);
        chk("rs_kill_instr", instr_out, NOP);
        chk("rs_req_vld", 32'(imem_req_valid), 32'd1);
        chk("rs_req_addr", imem_req_addr, 32'h80);
        stall = 1'b0;
        redirect_valid = 1'b0;
        wait_vld("pc80_vld", 6);
        chk("pc80_pc", if_id_pc, 32'h80);
        chk("pc80_instr", instr_out, 32'hFE00_0EE3);

        // Reset pulse in S_WAIT; late response must be ignored
        mem_auto = 1'b0;
        @(negedge clk);
        chk("pre_rst_waiting", 32'(imem_req_valid), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("arst_if_vld", 32'(if_id_valid), 32'd0);
        chk("arst_instr", instr_out, NOP);
        chk("arst_pc", if_id_pc, 32'd0);
        chk("arst_pc4", if_id_pc_plus4, 32'd4);
        chk("arst_req_vld", 32'(imem_req_valid), 32'd0);
        imem_resp_valid = 1'b1;
        imem_resp_data = 32'hBAD0_0BAD;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        imem_req_ready = 1'b0;
        @(negedge clk);
        chk("late_resp_ignored", 32'(if_id_valid), 32'd0);
        chk("refetch_vld", 32'(imem_req_valid), 32'd1);
        chk("refetch_addr", imem_req_addr, 32'h0);
        imem_resp_valid = 1'b0;
        imem_req_ready = 1'b1;
        mem_auto = 1'b1;
        wait_vld("refetch_load", 6);
        chk("refetch_pc", if_id_pc, 32'h0);
        chk("refetch_instr", instr_out, 32'h0050_0093);

        // PC wrap on the RESET_PC=0xFFFF_FFFC instance
        chk("wrap_req_vld", 32'(w_req_valid), 32'd1);
        chk("wrap_req_addr", w_req_addr, 32'hFFFF_FFFC);
        w_ready = 1'b1;
        @(negedge clk);
        w_ready = 1'b0;
        w_resp_valid = 1'b1;
        w_resp_data = 32'h1234_5013;
        @(negedge clk);
        w_resp_valid = 1'b0;
        chk("wrap_if_vld", 32'(w_if_valid), 32'd1);
        chk("wrap_if_pc", w_if_pc, 32'hFFFF_FFFC);
        chk("wrap_if_pc4", w_if_pc4, 32'h0);
        chk("wrap_instr", w_instr, 32'h1234_5013);
        chk("wrap_next_addr", w_req_addr, 32'h0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
